// File: rtl/linear_layer_srl_fifo_ctrl.sv
// linear_layer_srl_fifo_ctrl: SRL-backed handshaked FIFO between i4xi4 linear-layer dataflow tasks.
// Optional output register (capacity DEPTH+1, 2-cycle latency) enabled by SRL_FIFO_OUT_REG_EN.
module linear_layer_srl_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
);
    localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] LP_ONE  = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] r_srl [DEPTH];
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full_n;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_srl_pop;

    assign w_push    = if_write_ce & if_write & r_full_n;
    assign w_rd_addr = (r_count == '0) ? '0 : ADDR_WIDTH'(r_count - 1'b1);
    assign if_full_n = r_full_n;

    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = DEPTH - 1; i > 0; i--) r_srl[i] <= r_srl[i-1];
            r_srl[0] <= if_din;
        end
    end

    // w_srl_pop is the word leaving the shift array, which differs from the consumer pop when the output register is present
    always_ff @(posedge clk) begin
        if (!ap_rst_n) begin
            r_count  <= '0;
            r_full_n <= 1'b1;
        end else begin
            if (w_push & !w_srl_pop) r_count <= r_count + 1'b1;
            else if (w_srl_pop & !w_push) r_count <= r_count - 1'b1;
            if (w_push & !w_srl_pop & (r_count == LP_LAST)) r_full_n <= 1'b0;
            else if (w_srl_pop) r_full_n <= 1'b1;
        end
    end

`ifdef SRL_FIFO_OUT_REG_EN
    logic                  r_out_vld;
    logic [DATA_WIDTH-1:0] r_dout;

    assign w_pop      = if_read_ce & if_read & r_out_vld;
    assign w_srl_pop  = (!r_out_vld | w_pop) & (r_count != '0);
    assign if_empty_n = r_out_vld;
    assign if_dout    = r_dout;

    always_ff @(posedge clk) begin
        if (!ap_rst_n) begin
            r_out_vld <= 1'b0;
            r_dout    <= '0;
        end else if (w_srl_pop) begin
            r_out_vld <= 1'b1;
            r_dout    <= r_srl[w_rd_addr];
        end else if (w_pop) begin
            r_out_vld <= 1'b0;
        end
    end
`else
    logic r_empty_n;

    assign w_pop      = if_read_ce & if_read & r_empty_n;
    assign w_srl_pop  = w_pop;
    assign if_empty_n = r_empty_n;
    assign if_dout    = r_srl[w_rd_addr];

    always_ff @(posedge clk) begin
        if (!ap_rst_n) r_empty_n <= 1'b0;
        else if (w_push) r_empty_n <= 1'b1;
        else if (w_pop & (r_count == LP_ONE)) r_empty_n <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_linear_layer_srl_fifo_ctrl.sv
// tb_linear_layer_srl_fifo_ctrl: vector table, directed corner cases and random traffic against a queue model.
module tb_linear_layer_srl_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          if_write_ce = 1'b0, if_write = 1'b0, if_read_ce = 1'b0, if_read = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic [DW-1:0] if_dout;
    logic          if_full_n, if_empty_n;

    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] q [$];

    linear_layer_srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .ap_rst_n(ap_rst_n),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
        .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic [DW-1:0] din;
        logic          r;
        logic          e_n;
        logic          f_n;
        logic [DW-1:0] dout;
    } vec_t;

    task automatic cmp(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Occupancy bound, checked on every falling edge
    always @(negedge clk) begin
        n_chk++;
        if (dut.r_count > DEPTH) begin
            n_fail++;
            $display("FAIL occupancy: got %0d, expected <= %0d", dut.r_count, DEPTH);
        end
    end

    task automatic check_model(input string tag);
        cmp({tag, ".empty_n"}, int'(if_empty_n), int'(q.size() > 0));
        cmp({tag, ".full_n"}, int'(if_full_n), int'(q.size() < DEPTH));
        cmp({tag, ".count"}, int'(dut.r_count), q.size());
        if (q.size() > 0) cmp({tag, ".dout"}, int'(if_dout), int'(q[0]));
    endtask

    // One clock: drive, decide acceptance from the queue's own occupancy, advance the model
    task automatic cyc(input logic rst_n, input logic wce, input logic w, input logic [DW-1:0] din,
                       input logic rce, input logic r);
        bit push, pop;
        ap_rst_n = rst_n; if_write_ce = wce; if_write = w; if_din = din; if_read_ce = rce; if_read = r;
        push = wce && w && (q.size() < DEPTH);
        pop  = rce && r && (q.size() > 0);
        @(posedge clk);
        if (!rst_n) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(din);
        end
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d); cyc(1, 1, 1, d, 1, 0); endtask
    task automatic rd(); cyc(1, 1, 0, '0, 1, 1); endtask

    initial begin
        vec_t tbl [9];
        logic [DW-1:0] exp_seq [8];
        tbl = '{
            '{1, 8'h11, 0, 1, 1, 8'h11},
            '{1, 8'h22, 0, 1, 1, 8'h11},
            '{1, 8'h33, 0, 1, 1, 8'h11},
            '{1, 8'h44, 0, 1, 0, 8'h11},
            '{1, 8'h55, 0, 1, 0, 8'h11},
            '{0, 8'h00, 1, 1, 1, 8'h22},
            '{0, 8'h00, 1, 1, 1, 8'h33},
            '{0, 8'h00, 1, 1, 1, 8'h44},
            '{0, 8'h00, 1, 0, 1, 8'h00}
        };

        // Reset with a read request pending
        cyc(0, 1, 0, '0, 1, 1);
        cyc(0, 1, 0, '0, 1, 1);
        cmp("rst.empty_n", int'(if_empty_n), 0);
        cmp("rst.full_n", int'(if_full_n), 1);
        cyc(1, 1, 0, '0, 1, 1);
        cmp("rst.no_pop_count", int'(dut.r_count), 0);
        cmp("rst.no_pop_empty_n", int'(if_empty_n), 0);

        // Fill past full, then drain
        for (int i = 0; i < 9; i++) begin
            cyc(1, 1, tbl[i].w, tbl[i].din, 1, tbl[i].r);
            cmp($sformatf("vec%0d.empty_n", i), int'(if_empty_n), int'(tbl[i].e_n));
            cmp($sformatf("vec%0d.full_n", i), int'(if_full_n), int'(tbl[i].f_n));
            if (tbl[i].e_n) cmp($sformatf("vec%0d.dout", i), int'(if_dout), int'(tbl[i].dout));
            check_model($sformatf("vec%0d", i));
        end

        // Steady simultaneous push/pop at count 2
        exp_seq = '{8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        wr(8'hA1);
        wr(8'hA2);
        cmp("pp.head", int'(if_dout), int'(exp_seq[0]));
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 1, DW'(8'hB0 + i), 1, 1);
            cmp($sformatf("pp%0d.dout", i), int'(if_dout), int'(exp_seq[i+1]));
            cmp($sformatf("pp%0d.count", i), int'(dut.r_count), 2);
            check_model($sformatf("pp%0d", i));
        end

        // Full with both requested: pop wins
        wr(8'hC0);
        wr(8'hC1);
        cmp("full.full_n", int'(if_full_n), 0);
        cyc(1, 1, 1, 8'hEE, 1, 1);
        cmp("full_rw.count", int'(dut.r_count), 3);
        cmp("full_rw.full_n", int'(if_full_n), 1);
        check_model("full_rw");

        // Empty with both requested: push wins
        rd(); rd(); rd();
        cmp("drain.empty_n", int'(if_empty_n), 0);
        cyc(1, 1, 1, 8'h5A, 1, 1);
        cmp("empty_rw.empty_n", int'(if_empty_n), 1);
        cmp("empty_rw.dout", int'(if_dout), 8'h5A);
        check_model("empty_rw");

        // Clock enables low: requests ignored
        cyc(1, 0, 1, 8'h77, 1, 0);
        check_model("wce0");
        cyc(1, 1, 0, '0, 0, 1);
        check_model("rce0");
        cmp("ce0.count", int'(dut.r_count), 1);

        // Mid-operation reset at count 3
        wr(8'h61);
        wr(8'h62);
        cmp("pre_rst.count", int'(dut.r_count), 3);
        cyc(0, 1, 0, '0, 1, 0);
        cmp("mid_rst.count", int'(dut.r_count), 0);
        cmp("mid_rst.empty_n", int'(if_empty_n), 0);
        cmp("mid_rst.full_n", int'(if_full_n), 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                DW'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0));
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
